// File: rtl/term_pkg.sv
// Purpose: shared types and constants for the text-terminal video-memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package term_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_BACK   = 3'd3,
        ST_SCROLL = 3'd4
    } state_e;

    // Character RAM address layout is {col, phys_row}.
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;
    localparam int ADDR_W = COL_W + ROW_W;

    localparam logic [7:0] ASCII_ENTER = 8'd13;
    localparam logic [7:0] ASCII_BACK  = 8'd8;
    localparam logic [7:0] ASCII_BLANK = 8'h00;
    localparam logic [7:0] PRINT_LO    = 8'h20;
    localparam logic [7:0] PRINT_HI    = 8'h7E;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/vmem_ctrl_row_map.sv
// Purpose: map a logical screen row to a physical RAM row, (log + top) mod ROWS.
// Latency: combinational.
// Backpressure: none.
// Ports: i_log_row (logical row), i_top_row (physical row shown as row 0),
//        o_phys_row (physical row).
module row_map
    import term_pkg::*;
#(
    parameter int ROWS = 30
) (
    input  logic [ROW_W-1:0] i_log_row,
    input  logic [ROW_W-1:0] i_top_row,
    output logic [ROW_W-1:0] o_phys_row
);

    localparam logic [ROW_W:0] ROWS_W = (ROW_W+1)'(ROWS);

    logic [ROW_W:0] w_sum;

    // Both operands are < ROWS, so a single conditional subtract suffices.
    assign w_sum      = {1'b0, i_log_row} + {1'b0, i_top_row};
    assign o_phys_row = (w_sum >= ROWS_W) ? ROW_W'(w_sum - ROWS_W) : w_sum[ROW_W-1:0];

endmodule

// File: rtl/vmem_ctrl.sv
// Purpose: sequence keyboard ASCII into character RAM; owns cursor, clear and scroll.
// Latency: key accepted in N -> RAM write in N+1 -> cursor updated, ready again in N+2.
// Backpressure: key_ready only in IDLE; key_valid must hold until accepted.
//
// Ports: clk, reset (async active-low); key_in/key_valid/key_ready keyboard
// handshake; wr_en/wr_addr/wr_data character RAM write port, wr_addr = {col, phys_row};
// top_row physical row displayed as logical row 0; cursor_x/cursor_y logical cursor;
// busy high while clearing or scrolling.
// Build option VMEM_SCROLL_EN: when defined the screen scrolls by moving top_row;
// otherwise top_row stays 0 and a newline on the last row wraps the cursor to (0,0)
// after blanking physical row 0.
module vmem_ctrl
    import term_pkg::*;
#(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ROW_W-1:0]  top_row,
    output logic [COL_W-1:0]  cursor_x,
    output logic [ROW_W-1:0]  cursor_y,
    output logic              busy
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COLS_C   = COL_W'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROWS_R   = ROW_W'(ROWS);

    state_e r_state;
    state_e w_state_nxt;

    logic [7:0]       r_key,     w_key_nxt;
    logic [COL_W-1:0] r_cx,      w_cx_nxt;
    logic [ROW_W-1:0] r_cy,      w_cy_nxt;
    logic [ROW_W-1:0] r_top,     w_top_nxt;
    logic [ROW_W-1:0] r_scr_row, w_scr_row_nxt;
    logic [COL_W-1:0] r_cnt_col, w_cnt_col_nxt;
    logic [ROW_W-1:0] r_cnt_row, w_cnt_row_nxt;
    logic             r_wr_en,   w_wr_en_nxt;
    logic [COL_W-1:0] r_wr_col,  w_wr_col_nxt;
    logic [ROW_W-1:0] r_wr_row,  w_wr_row_nxt;
    logic [7:0]       r_wr_data, w_wr_data_nxt;

    logic             w_hs;
    logic             w_key_back;
    logic             w_bk_move;
    logic [COL_W-1:0] w_bk_x;
    logic [ROW_W-1:0] w_bk_y;
    logic [ROW_W-1:0] w_map_row;
    logic [ROW_W-1:0] w_phys_row;
    logic             w_cur_print;
    logic             w_do_nl;
    logic             w_nl_last;

    assign w_hs       = key_valid && (r_state == ST_IDLE);
    assign w_key_back = (key_in == ASCII_BACK);

    // Backspace target cell; at (0,0) the key is ignored.
    assign w_bk_move = (r_cx != '0) || (r_cy != '0);
    assign w_bk_x    = (r_cx == '0) ? LAST_COL : r_cx - COL_W'(1);
    assign w_bk_y    = (r_cx == '0) ? r_cy - ROW_W'(1) : r_cy;

    // Backspace blanks the cell it moves to, so its address uses the new row.
    assign w_map_row = w_key_back ? w_bk_y : r_cy;

    row_map #(.ROWS(ROWS)) u_row_map (
        .i_log_row  (w_map_row),
        .i_top_row  (r_top),
        .o_phys_row (w_phys_row)
    );

    // Cursor action for the latched key while in WRITE.
    assign w_cur_print = is_printable(r_key);
    assign w_do_nl     = (w_cur_print && (r_cx == LAST_COL)) || (r_key == ASCII_ENTER);
    assign w_nl_last   = (r_cy == LAST_ROW);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_cnt_row == ROWS_R) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_hs) w_state_nxt = w_key_back ? ST_BACK : ST_WRITE;
            end
            ST_WRITE: begin
                w_state_nxt = (w_do_nl && w_nl_last) ? ST_SCROLL : ST_IDLE;
            end
            ST_BACK: begin
                w_state_nxt = ST_IDLE;
            end
            ST_SCROLL: begin
                if (r_cnt_col == COLS_C) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // Output/datapath logic. Write-port values are computed one cycle ahead and
    // registered, so the RAM strobe appears in the cycle after the decision.
    always_comb begin
        w_key_nxt     = r_key;
        w_cx_nxt      = r_cx;
        w_cy_nxt      = r_cy;
        w_top_nxt     = r_top;
        w_scr_row_nxt = r_scr_row;
        w_cnt_col_nxt = r_cnt_col;
        w_cnt_row_nxt = r_cnt_row;
        w_wr_en_nxt   = 1'b0;
        w_wr_col_nxt  = r_wr_col;
        w_wr_row_nxt  = r_wr_row;
        w_wr_data_nxt = r_wr_data;
        case (r_state)
            ST_CLEAR: begin
                // r_cnt_row reaching ROWS marks every cell as issued.
                if (r_cnt_row != ROWS_R) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_col_nxt  = r_cnt_col;
                    w_wr_row_nxt  = r_cnt_row;
                    w_wr_data_nxt = ASCII_BLANK;
                    if (r_cnt_col == LAST_COL) begin
                        w_cnt_col_nxt = '0;
                        w_cnt_row_nxt = r_cnt_row + ROW_W'(1);
                    end else begin
                        w_cnt_col_nxt = r_cnt_col + COL_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (w_hs) begin
                    w_key_nxt = key_in;
                    if (w_key_back) begin
                        if (w_bk_move) begin
                            w_wr_en_nxt   = 1'b1;
                            w_wr_col_nxt  = w_bk_x;
                            w_wr_row_nxt  = w_phys_row;
                            w_wr_data_nxt = ASCII_BLANK;
                        end
                    end else if (is_printable(key_in)) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_col_nxt  = r_cx;
                        w_wr_row_nxt  = w_phys_row;
                        w_wr_data_nxt = key_in;
                    end
                end
            end
            ST_WRITE: begin
                if (w_do_nl) begin
                    w_cx_nxt = '0;
                    if (!w_nl_last) begin
                        w_cy_nxt = r_cy + ROW_W'(1);
                    end else begin
                        // The row leaving the top (old top_row) becomes the new
                        // bottom row; its first blank is issued on entry.
                        w_scr_row_nxt = r_top;
                        w_cnt_col_nxt = COL_W'(1);
                        w_wr_en_nxt   = 1'b1;
                        w_wr_col_nxt  = '0;
                        w_wr_row_nxt  = r_top;
                        w_wr_data_nxt = ASCII_BLANK;
`ifdef VMEM_SCROLL_EN
                        w_top_nxt = (r_top == LAST_ROW) ? '0 : r_top + ROW_W'(1);
`else
                        w_cy_nxt = '0;
`endif
                    end
                end else if (w_cur_print) begin
                    w_cx_nxt = r_cx + COL_W'(1);
                end
            end
            ST_BACK: begin
                if (w_bk_move) begin
                    w_cx_nxt = w_bk_x;
                    w_cy_nxt = w_bk_y;
                end
            end
            ST_SCROLL: begin
                if (r_cnt_col != COLS_C) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_col_nxt  = r_cnt_col;
                    w_wr_row_nxt  = r_scr_row;
                    w_wr_data_nxt = ASCII_BLANK;
                    w_cnt_col_nxt = r_cnt_col + COL_W'(1);
                end
            end
            default: begin
                w_wr_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key     <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_top     <= '0;
            r_scr_row <= '0;
            r_cnt_col <= '0;
            r_cnt_row <= '0;
            r_wr_en   <= 1'b0;
            r_wr_col  <= '0;
            r_wr_row  <= '0;
            r_wr_data <= '0;
        end else begin
            r_key     <= w_key_nxt;
            r_cx      <= w_cx_nxt;
            r_cy      <= w_cy_nxt;
            r_top     <= w_top_nxt;
            r_scr_row <= w_scr_row_nxt;
            r_cnt_col <= w_cnt_col_nxt;
            r_cnt_row <= w_cnt_row_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_col  <= w_wr_col_nxt;
            r_wr_row  <= w_wr_row_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    assign key_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_CLEAR) || (r_state == ST_SCROLL);
    assign wr_en     = r_wr_en;
    assign wr_addr   = {r_wr_col, r_wr_row};
    assign wr_data   = r_wr_data;
    assign top_row   = r_top;
    assign cursor_x  = r_cx;
    assign cursor_y  = r_cy;

endmodule

// File: doc/vmem_ctrl.md
# vmem_ctrl

Text-terminal controller that sequences PS/2 ASCII input into the character video memory. It owns the cursor and interprets printable characters, ENTER and BACKSPACE. It clears memory after reset and scrolls the screen when the cursor runs off the bottom row. It sits between the keyboard decoder and the write port of the character RAM; the VGA side reads the RAM and uses `top_row` to map logical rows to physical rows.

## Interface
Parameters:
- COLS, 70, characters per row; 1..127.
- ROWS, 30, rows per screen; 1..31.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_in  in  8  ASCII code from keyboard decoder.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  controller accepts key this cycle.
- wr_en  out  1  character RAM write strobe.
- wr_addr  out  12  RAM address {col[6:0], phys_row[4:0]}.
- wr_data  out  8  character to write.
- top_row  out  5  physical row shown as logical row 0.
- cursor_x  out  7  logical cursor column.
- cursor_y  out  5  logical cursor row.
- busy  out  1  clear or scroll sequence in progress.

## Operation
- States: CLEAR, IDLE, WRITE, BACK, SCROLL.
- Reset values: state CLEAR; all outputs 0 except busy=1.
- Address mapping: phys_row = cursor_y + top_row, minus ROWS if the sum is ≥ ROWS.
- CLEAR:
  - Writes 0x00 to every cell, column-inner then row, over COLS·ROWS cycles.
  - Then goes to IDLE; busy drops.
- IDLE:
  - key_ready=1 only in IDLE.
  - A handshake (key_valid && key_ready) latches key_in.
- Printable key (0x20..0x7E), state WRITE, one cycle:
  - wr_en=1 at the cursor.
  - Cursor then advances: x+1.
  - If x==COLS-1, perform a newline instead of advancing.
- ENTER (0x0D):
  - No write; perform a newline.
- BACKSPACE (0x08), state BACK:
  - At (0,0): ignored.
  - At x=0, y>0: cursor moves to (COLS-1, y-1).
  - Otherwise: cursor moves to x-1.
  - In both moving cases the new cursor cell gets 0x00 written in the same cycle (wr_addr computed from the new position).
- Other codes: consumed with no effect; return to IDLE next cycle.
- Newline:
  - If y<ROWS-1: x=0, y+1.
  - Else: x=0, y unchanged, enter SCROLL.
- SCROLL:
  - top_row increments mod ROWS on entry.
  - Writes 0x00 to the COLS cells of the new bottom row, i.e. the physical row that was previously on top.
  - busy=1 throughout; then IDLE.
- Keys are never dropped: key_valid must hold until ready; the controller never accepts during CLEAR, WRITE, BACK or SCROLL.

## Timing
- Accept in cycle N → wr_en in N+1 → cursor outputs updated and key_ready high in N+2, unless scrolling.
- Scroll: wr_en high for exactly COLS consecutive cycles starting N+2; key_ready returns the cycle after the last write.
- CLEAR lasts COLS·ROWS cycles after reset release (2100 with defaults).
- Asserting reset at any point, including mid-scroll, immediately returns all state to reset values; CLEAR restarts from cell 0 after release.
- Outputs are registered; wr_* are never combinational from key_in.

## Configuration
- VMEM_SCROLL_EN defined: scrolling as above; top_row moves.
- Undefined:
  - top_row fixed at 0.
  - A newline at the last row sets the cursor to (0,0).
  - SCROLL clears physical row 0 (COLS writes) before IDLE.

## Structure
- Package term_pkg:
  - State enum.
  - Constants ASCII_ENTER=13, ASCII_BACK=8, ASCII_BLANK=0, PRINT_LO=0x20, PRINT_HI=0x7E.
  - Address width constants (col 7, row 5).
- One sub-module, row_map: combinational logical-to-physical row add mod ROWS, instantiated for the write address.

## Test plan
- Reset release → 2100 write strobes, all with wr_data 0x00, covering every address; then key_ready=1, busy=0.
- Keys 'A','B' → writes 0x41 @ {0,0}, 0x42 @ {1,0}; cursor (2,0).
- 70 × 'x' on row 0 → last write @ {69,0}; cursor (0,1).
- BACKSPACE at (0,1) → write 0x00 @ {69,0}; cursor (69,0). BACKSPACE at (0,0) → no write, cursor stays.
- 30 ENTERs from (0,0) with VMEM_SCROLL_EN → top_row=1, 70 writes of 0x00 to physical row 0, cursor (0,29). Next 'Z' → write @ {0,0}.
- Reset asserted during a scroll → outputs return to reset values at once; a full CLEAR follows release.
